// File: rtl/multicycle_processor_if.sv
// Shared memory port of the multicycle core: one request at a time, completed by memReady.
interface multicycle_processor_if #(
  parameter int OPERAND_LENGTH = 31
);
  logic [OPERAND_LENGTH:0] readDataMem;
  logic                    memReady;
  logic [OPERAND_LENGTH:0] memAddress;
  logic [OPERAND_LENGTH:0] writeDataMem;
  logic                    memRead;
  logic                    memWrite;

  modport master (
    input  readDataMem, memReady,
    output memAddress, writeDataMem, memRead, memWrite
  );

  modport slave (
    output readDataMem, memReady,
    input  memAddress, writeDataMem, memRead, memWrite
  );
endinterface

// File: rtl/multicycle_processor.sv
// Multicycle RV32I-subset core (R, I-ALU, lw, sw, beq/bne) sequenced over one shared memory port.
// Optional PERF_COUNTERS_EN adds cycleCount / instRetired outputs.
module multicycle_processor #(
  parameter int                    OPERAND_LENGTH = 31,
  parameter logic [OPERAND_LENGTH:0] RESET_PC     = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_processor_if.master  bus,
  output logic [OPERAND_LENGTH:0] pcOut,
  output logic                    halted,
  output logic [15:0]             leds
`ifdef PERF_COUNTERS_EN
  ,
  output logic [OPERAND_LENGTH:0] cycleCount,
  output logic [OPERAND_LENGTH:0] instRetired
`endif
);
  localparam int W   = OPERAND_LENGTH + 1;
  localparam int SHW = $clog2(W);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_pc, r_ir, r_a, r_b, r_imm, r_aluout, r_mdr;
  logic [W-1:0]     r_regs [32];
  logic             r_memRead, r_memWrite;
  logic             w_memRead_nxt, w_memWrite_nxt, w_retire;

  // Instruction fields
  logic [6:0]       w_opcode;
  logic [4:0]       w_rd, w_rs1, w_rs2;
  logic [2:0]       w_f3;
  logic             w_f7b5;
  logic             w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_br, w_supported;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_f7b5   = r_ir[30];

  assign w_is_r      = (w_opcode == OP_R);
  assign w_is_i      = (w_opcode == OP_I);
  assign w_is_lw     = (w_opcode == OP_LW);
  assign w_is_sw     = (w_opcode == OP_SW);
  assign w_is_br     = (w_opcode == OP_BR);
  assign w_supported = w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_br;

  // Immediate generator
  logic [W-1:0] w_imm;
  always_comb begin
    w_imm = '0;
    if (w_is_i || w_is_lw)
      w_imm = {{(W-12){r_ir[31]}}, r_ir[31:20]};
    else if (w_is_sw)
      w_imm = {{(W-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    else if (w_is_br)
      w_imm = {{(W-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  end

  // ALU control: funct7[5] selects sub only for R-type, sra for both shift forms
  alu_op_t w_alu_op;
  always_comb begin
    w_alu_op = ALU_ADD;
    if (w_is_r || w_is_i) begin
      case (w_f3)
        3'b000:  w_alu_op = (w_is_r && w_f7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  w_alu_op = ALU_SLL;
        3'b010:  w_alu_op = ALU_SLT;
        3'b011:  w_alu_op = ALU_SLTU;
        3'b100:  w_alu_op = ALU_XOR;
        3'b101:  w_alu_op = w_f7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  w_alu_op = ALU_OR;
        default: w_alu_op = ALU_AND;
      endcase
    end else if (w_is_br) begin
      w_alu_op = ALU_SUB;
    end
  end

  // ALU
  logic [W-1:0]   w_alu_b, w_alu_res;
  logic [SHW-1:0] w_shamt;
  logic           w_zero, w_alusrc, w_taken;

  assign w_alusrc = ~(w_is_r | w_is_br);
  assign w_alu_b  = w_alusrc ? r_imm : r_b;
  assign w_shamt  = w_alu_b[SHW-1:0];

  always_comb begin
    w_alu_res = '0;
    case (w_alu_op)
      ALU_ADD:  w_alu_res = r_a + w_alu_b;
      ALU_SUB:  w_alu_res = r_a - w_alu_b;
      ALU_SLL:  w_alu_res = r_a << w_shamt;
      ALU_SLT:  w_alu_res = {{(W-1){1'b0}}, ($signed(r_a) < $signed(w_alu_b))};
      ALU_SLTU: w_alu_res = {{(W-1){1'b0}}, (r_a < w_alu_b)};
      ALU_XOR:  w_alu_res = r_a ^ w_alu_b;
      ALU_SRL:  w_alu_res = r_a >> w_shamt;
      ALU_SRA:  w_alu_res = $signed(r_a) >>> w_shamt;
      ALU_OR:   w_alu_res = r_a | w_alu_b;
      ALU_AND:  w_alu_res = r_a & w_alu_b;
      default:  w_alu_res = '0;
    endcase
  end

  assign w_zero  = (w_alu_res == '0);
  assign w_taken = w_f3[0] ? ~w_zero : w_zero;

  // memReady only counts while a request is actually outstanding
  logic w_mem_acc;
  assign w_mem_acc = (r_memRead | r_memWrite) & bus.memReady;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  // Next state; request strobes are computed one cycle ahead so they leave a flop
  always_comb begin
    w_state_nxt    = r_state;
    w_memRead_nxt  = 1'b0;
    w_memWrite_nxt = 1'b0;
    w_retire       = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_mem_acc) w_state_nxt   = S_DECODE;
        else           w_memRead_nxt = 1'b1;
      end
      S_DECODE: begin
        w_state_nxt = w_supported ? S_EXECUTE : S_HALT;
      end
      S_EXECUTE: begin
        if (w_is_br) begin
          w_state_nxt   = S_FETCH;
          w_memRead_nxt = 1'b1;
          w_retire      = 1'b1;
        end else if (w_is_lw) begin
          w_state_nxt   = S_MEM;
          w_memRead_nxt = 1'b1;
        end else if (w_is_sw) begin
          w_state_nxt    = S_MEM;
          w_memWrite_nxt = 1'b1;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (w_is_lw) begin
          if (w_mem_acc) w_state_nxt   = S_WB;
          else           w_memRead_nxt = 1'b1;
        end else begin
          if (w_mem_acc) begin
            w_state_nxt   = S_FETCH;
            w_memRead_nxt = 1'b1;
            w_retire      = 1'b1;
          end else begin
            w_memWrite_nxt = 1'b1;
          end
        end
      end
      S_WB: begin
        w_state_nxt   = S_FETCH;
        w_memRead_nxt = 1'b1;
        w_retire      = 1'b1;
      end
      default: w_state_nxt = S_HALT;
    endcase
  end

  // Datapath registers and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_imm      <= '0;
      r_aluout   <= '0;
      r_mdr      <= '0;
      r_memRead  <= 1'b0;
      r_memWrite <= 1'b0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      r_memRead  <= w_memRead_nxt;
      r_memWrite <= w_memWrite_nxt;
      case (r_state)
        S_FETCH: if (w_mem_acc) r_ir <= bus.readDataMem;
        S_DECODE: begin
          r_a   <= r_regs[w_rs1];
          r_b   <= r_regs[w_rs2];
          r_imm <= w_imm;
        end
        S_EXECUTE: begin
          r_aluout <= w_alu_res;
          if (w_is_br) r_pc <= w_taken ? r_pc + r_imm : r_pc + W'(4);
        end
        S_MEM: begin
          if (w_mem_acc && w_is_lw) r_mdr <= bus.readDataMem;
          if (w_mem_acc && w_is_sw) r_pc  <= r_pc + W'(4);
        end
        S_WB: begin
          if (w_rd != 5'd0) r_regs[w_rd] <= w_is_lw ? r_mdr : r_aluout;
          r_pc <= r_pc + W'(4);
        end
        default: ;
      endcase
    end
  end

  assign bus.memRead      = r_memRead;
  assign bus.memWrite     = r_memWrite;
  assign bus.memAddress   = (r_state == S_FETCH && r_memRead) ? r_pc :
                            (r_state == S_MEM && (r_memRead | r_memWrite)) ? r_aluout : '0;
  assign bus.writeDataMem = r_memWrite ? r_b : '0;

  assign pcOut  = r_pc;
  assign halted = (r_state == S_HALT);
  assign leds   = {12'd0, halted, r_state};

`ifdef PERF_COUNTERS_EN
  logic [W-1:0] r_cycleCount, r_instRetired;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycleCount  <= '0;
      r_instRetired <= '0;
    end else begin
      r_cycleCount <= r_cycleCount + W'(1);
      if (w_retire) r_instRetired <= r_instRetired + W'(1);
    end
  end
  assign cycleCount  = r_cycleCount;
  assign instRetired = r_instRetired;
`endif
endmodule

// File: tb/tb_multicycle_processor.sv
// Scoreboard bench: expected bus transactions (with fetch-to-fetch latency) are queued up front
// and a monitor checks each accepted transaction; directed checks cover reset and halt.
module tb_multicycle_processor;
  logic clk, rst;
  logic [31:0] pcOut;
  logic        halted;
  logic [15:0] leds;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cycleCount, instRetired;
`endif

  multicycle_processor_if #(.OPERAND_LENGTH(31)) bus();

  multicycle_processor #(.OPERAND_LENGTH(31), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pcOut(pcOut), .halted(halted), .leds(leds)
`ifdef PERF_COUNTERS_EN
    , .cycleCount(cycleCount), .instRetired(instRetired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 fetch, 1 data read, 2 write
    logic [31:0] addr;
    logic [31:0] data;
    int          gap;    // expected cycles since previous fetch accept, -1 = skip
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0, n_err = 0;
  logic [31:0] mem [256];

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push(int k, logic [31:0] a, logic [31:0] d, int g);
    exp_t e;
    e.kind = k; e.addr = a; e.data = d; e.gap = g;
    q.push_back(e);
  endtask

  function automatic int stall_for(logic [31:0] a);
    if (a == 32'h100) return 3;
    if (a == 32'h28)  return 2;
    return 0;
  endfunction

  // Memory responder: requests sampled at negedge, completion applied at the following posedge
  initial begin
    logic        s_req, s_wr;
    logic [31:0] s_addr, s_data;
    int          wcnt;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[32'h00 >> 2] = 32'h00500093;  // addi x1,x0,5
    mem[32'h04 >> 2] = 32'h00108133;  // add  x2,x1,x1
    mem[32'h08 >> 2] = 32'h20202223;  // sw   x2,0x204(x0)
    mem[32'h0C >> 2] = 32'h10002183;  // lw   x3,0x100(x0)
    mem[32'h10 >> 2] = 32'h20302423;  // sw   x3,0x208(x0)
    mem[32'h14 >> 2] = 32'h00000663;  // beq  x0,x0,+12
    mem[32'h18 >> 2] = 32'h0000007F;  // must be skipped
    mem[32'h1C >> 2] = 32'h00000663;  // beq  x0,x0,+12
    mem[32'h20 >> 2] = 32'hFE001CE3;  // bne  x0,x0,-8 (not taken)
    mem[32'h24 >> 2] = 32'hFE000CE3;  // beq  x0,x0,-8
    mem[32'h28 >> 2] = 32'h00700013;  // addi x0,x0,7
    mem[32'h2C >> 2] = 32'h20002623;  // sw   x0,0x20C(x0)
    mem[32'h30 >> 2] = 32'h40218233;  // sub  x4,x3,x2
    mem[32'h34 >> 2] = 32'h20402823;  // sw   x4,0x210(x0)
    mem[32'h38 >> 2] = 32'hFFF00293;  // addi x5,x0,-1
    mem[32'h3C >> 2] = 32'h20502A23;  // sw   x5,0x214(x0)
    mem[32'h40 >> 2] = 32'h0000007F;  // halt
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    bus.memReady = 1'b0;
    bus.readDataMem = 32'h0;
    s_req = 0; s_wr = 0; s_addr = 0; s_data = 0; wcnt = 0;
    forever begin
      @(posedge clk);
      if (!rst && s_req && bus.memReady) begin
        if (s_wr) mem[s_addr[9:2]] = s_data;
        wcnt = 0;
      end else if (!rst && s_req) wcnt++;
      else wcnt = 0;
      @(negedge clk);
      #1;
      s_req  = bus.memRead | bus.memWrite;
      s_wr   = bus.memWrite;
      s_addr = bus.memAddress;
      s_data = bus.writeDataMem;
      bus.memReady    = s_req && (wcnt >= stall_for(s_addr));
      bus.readDataMem = mem[s_addr[9:2]];
    end
  end

  // Monitor: every transaction about to be accepted is checked against the queue head
  initial begin
    int cyc = 0, last_fetch = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst && bus.memReady && (bus.memRead || bus.memWrite)) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_txn: addr %h rd %b wr %b with empty queue", bus.memAddress, bus.memRead, bus.memWrite);
        end else begin
          e = q.pop_front();
          chk("txn_is_write", {31'd0, bus.memWrite}, {31'd0, (e.kind == 2)});
          chk("txn_addr", bus.memAddress, e.addr);
          if (e.kind == 2) chk("store_data", bus.writeDataMem, e.data);
          if (e.kind == 0) begin
            chk("fetch_pcOut", pcOut, e.addr);
            if (e.gap >= 0) chk("fetch_latency", cyc - last_fetch, e.gap);
            last_fetch = cyc;
          end
        end
      end
    end
  end

  task automatic drain(int budget);
    int t = 0;
    while (q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d transactions still pending, expected 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    rst = 1'b1;
    push(0, 32'h00, 0, -1);
    push(0, 32'h04, 0, 4);
    push(0, 32'h08, 0, 4);
    push(2, 32'h204, 32'd10, 0);
    push(0, 32'h0C, 0, 4);
    push(1, 32'h100, 0, 0);
    push(0, 32'h10, 0, 8);            // lw 5 + 3 stall cycles
    push(2, 32'h208, 32'hDEADBEEF, 0);
    push(0, 32'h14, 0, 4);
    push(0, 32'h20, 0, 3);
    push(0, 32'h24, 0, 3);
    push(0, 32'h1C, 0, 3);
    push(0, 32'h28, 0, 5);            // branch 3 + 2 fetch stall cycles
    push(0, 32'h2C, 0, 4);
    push(2, 32'h20C, 32'h0, 0);
    push(0, 32'h30, 0, 4);
    push(0, 32'h34, 0, 4);
    push(2, 32'h210, 32'hDEADBEE5, 0);
    push(0, 32'h38, 0, 4);
    push(0, 32'h3C, 0, 4);
    push(2, 32'h214, 32'hFFFFFFFF, 0);
    push(0, 32'h40, 0, 4);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pcOut", pcOut, 32'h0);
    chk("rst_memRead", {31'd0, bus.memRead}, 32'd0);
    chk("rst_memWrite", {31'd0, bus.memWrite}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_leds", {16'd0, leds}, 32'd0);
    chk("rst_memAddress", bus.memAddress, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_fetch_memRead", {31'd0, bus.memRead}, 32'd1);
    chk("first_fetch_addr", bus.memAddress, 32'h0);

    drain(400);
    repeat (3) @(negedge clk);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_leds", {16'd0, leds}, 32'h0000000D);
    busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.memRead || bus.memWrite) busy++;
    end
    chk("halt_no_requests", busy, 0);
    chk("halt_sticky", {31'd0, halted}, 32'd1);

    push(0, 32'h00, 0, -1);
    rst = 1'b1;
    @(negedge clk);
    chk("rerst_pcOut", pcOut, 32'h0);
    chk("rerst_halted", {31'd0, halted}, 32'd0);
    chk("rerst_memRead", {31'd0, bus.memRead}, 32'd0);
    rst = 1'b0;
    drain(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
